// File: rtl/spi_bus_bridge.sv
// SPI byte stream to timed host-bus cycles, with read data returned on the SPI transmit byte.
// Optional feature: define SPI_BURST_EN for multi-byte bursts within one select.
module spi_bus_bridge #(
  parameter int unsigned CS_HOLD   = 2,
  parameter int unsigned REG_BITS  = 4,
  parameter logic [7:0]  IDLE_BYTE = 8'hCB
) (
  input  logic                clk,
  input  logic                reset_i,
  input  logic                select_i,
  input  logic                receive_strobe_i,
  input  logic [7:0]          receive_byte_i,
  input  logic                transmit_strobe_i,
  output logic [7:0]          transmit_byte_o,
  output logic                bus_cs_n_o,
  output logic                bus_rd_nwr_o,
  output logic                bus_bytesel_o,
  output logic [REG_BITS-1:0] bus_reg_num_o,
  output logic [7:0]          bus_data_o,
  input  logic [7:0]          bus_data_i,
  output logic                soft_reset_o,
  output logic                overrun_o
);

`ifdef SPI_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  typedef enum logic [1:0] {S_CMD, S_PAY, S_BUS} state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic                w_cmd_latch;
  logic                w_start_bus;
  logic                w_pay_write;
  logic                w_bus_done;
  logic                w_overrun_set;

  logic                r_cmd_cs;
  logic                r_cmd_wr;
  logic [3:0]          r_cnt;
  logic                r_cs_n;
  logic                r_rd_nwr;
  logic                r_bytesel;
  logic [REG_BITS-1:0] r_reg_num;
  logic [7:0]          r_data_out;
  logic [7:0]          r_rd_data;
  logic                r_rd_valid;
  logic                r_soft_reset;
  logic                r_overrun;

  always_ff @(posedge clk) begin
    if (reset_i) r_state <= S_CMD;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    w_cmd_latch   = 1'b0;
    w_start_bus   = 1'b0;
    w_pay_write   = 1'b0;
    w_bus_done    = 1'b0;
    w_overrun_set = 1'b0;
    case (r_state)
      S_CMD: begin
        if (!select_i) begin
          w_state_next = S_CMD;
        end else if (receive_strobe_i) begin
          w_cmd_latch = 1'b1;
          if (receive_byte_i[7] && !receive_byte_i[6]) begin
            w_start_bus  = 1'b1;
            w_state_next = S_BUS;
          end else begin
            w_state_next = S_PAY;
          end
        end
      end
      S_PAY: begin
        if (!select_i) begin
          w_state_next = S_CMD;
        end else if (BURST && r_cmd_cs && !r_cmd_wr && transmit_strobe_i) begin
          // burst read: refill the transmit byte as soon as the previous one is taken
          w_start_bus  = 1'b1;
          w_state_next = S_BUS;
        end else if (receive_strobe_i) begin
          if (r_cmd_cs && r_cmd_wr) begin
            w_pay_write  = 1'b1;
            w_start_bus  = 1'b1;
            w_state_next = S_BUS;
          end else begin
            w_state_next = BURST ? S_PAY : S_CMD;
          end
        end
      end
      S_BUS: begin
        w_overrun_set = receive_strobe_i;
        if (r_cnt == 4'd1) begin
          w_bus_done = 1'b1;
          if (!select_i)     w_state_next = S_CMD;
          else if (r_rd_nwr) w_state_next = S_PAY;
          else               w_state_next = BURST ? S_PAY : S_CMD;
        end
      end
      default: w_state_next = S_CMD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_cmd_cs     <= 1'b0;
      r_cmd_wr     <= 1'b0;
      r_cnt        <= '0;
      r_cs_n       <= 1'b1;
      r_rd_nwr     <= 1'b1;
      r_bytesel    <= 1'b0;
      r_reg_num    <= '0;
      r_data_out   <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
      r_soft_reset <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_soft_reset <= w_cmd_latch && receive_byte_i[5];
      if (w_cmd_latch) begin
        r_cmd_cs  <= receive_byte_i[7];
        r_cmd_wr  <= receive_byte_i[6];
        r_rd_nwr  <= ~receive_byte_i[6];
        r_bytesel <= receive_byte_i[4];
        r_reg_num <= receive_byte_i[REG_BITS-1:0];
        r_overrun <= 1'b0;
      end else if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
      if (w_pay_write) r_data_out <= receive_byte_i;
      if (w_start_bus) begin
        r_cs_n <= 1'b0;
        r_cnt  <= 4'(CS_HOLD);
      end else if (r_state == S_BUS) begin
        r_cnt <= r_cnt - 4'd1;
        if (w_bus_done) begin
          r_cs_n <= 1'b1;
          if (BURST)    r_bytesel <= ~r_bytesel;
          if (r_rd_nwr) r_rd_data <= bus_data_i;
        end
      end
      if (!select_i)                     r_rd_valid <= 1'b0;
      else if (w_bus_done && r_rd_nwr)   r_rd_valid <= 1'b1;
      else if (transmit_strobe_i)        r_rd_valid <= 1'b0;
    end
  end

  assign transmit_byte_o = r_rd_valid ? r_rd_data : IDLE_BYTE;
  assign bus_cs_n_o      = r_cs_n;
  assign bus_rd_nwr_o    = r_rd_nwr;
  assign bus_bytesel_o   = r_bytesel;
  assign bus_reg_num_o   = r_reg_num;
  assign bus_data_o      = r_data_out;
  assign soft_reset_o    = r_soft_reset;
  assign overrun_o       = r_overrun;

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Directed self-checking bench for spi_bus_bridge (CS_HOLD=2, REG_BITS=4, IDLE_BYTE=8'hCB).
module tb_spi_bus_bridge;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       select_i;
  logic       receive_strobe_i;
  logic [7:0] receive_byte_i;
  logic       transmit_strobe_i;
  logic [7:0] transmit_byte_o;
  logic       bus_cs_n_o;
  logic       bus_rd_nwr_o;
  logic       bus_bytesel_o;
  logic [3:0] bus_reg_num_o;
  logic [7:0] bus_data_o;
  logic [7:0] bus_data_i;
  logic       soft_reset_o;
  logic       overrun_o;

  int checks = 0;
  int errors = 0;

  spi_bus_bridge #(
    .CS_HOLD  (2),
    .REG_BITS (4),
    .IDLE_BYTE(8'hCB)
  ) dut (
    .clk              (clk),
    .reset_i          (reset_i),
    .select_i         (select_i),
    .receive_strobe_i (receive_strobe_i),
    .receive_byte_i   (receive_byte_i),
    .transmit_strobe_i(transmit_strobe_i),
    .transmit_byte_o  (transmit_byte_o),
    .bus_cs_n_o       (bus_cs_n_o),
    .bus_rd_nwr_o     (bus_rd_nwr_o),
    .bus_bytesel_o    (bus_bytesel_o),
    .bus_reg_num_o    (bus_reg_num_o),
    .bus_data_o       (bus_data_o),
    .bus_data_i       (bus_data_i),
    .soft_reset_o     (soft_reset_o),
    .overrun_o        (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    receive_byte_i   = b;
    receive_strobe_i = 1'b1;
    tick();
    receive_strobe_i = 1'b0;
  endtask

  task automatic deselect();
    select_i = 1'b0;
    repeat (4) tick();
    select_i = 1'b1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    repeat (3) tick();
    checks++; if (bus_cs_n_o !== 1'b1) begin errors++; $display("FAIL rst_cs_n got %0h exp 1", bus_cs_n_o); end
    checks++; if (bus_rd_nwr_o !== 1'b1) begin errors++; $display("FAIL rst_rd_nwr got %0h exp 1", bus_rd_nwr_o); end
    checks++; if (bus_bytesel_o !== 1'b0) begin errors++; $display("FAIL rst_bytesel got %0h exp 0", bus_bytesel_o); end
    checks++; if (bus_reg_num_o !== 4'h0) begin errors++; $display("FAIL rst_reg got %0h exp 0", bus_reg_num_o); end
    checks++; if (bus_data_o !== 8'h00) begin errors++; $display("FAIL rst_data got %0h exp 00", bus_data_o); end
    checks++; if (transmit_byte_o !== 8'hCB) begin errors++; $display("FAIL rst_tx got %0h exp cb", transmit_byte_o); end
    checks++; if (soft_reset_o !== 1'b0) begin errors++; $display("FAIL rst_soft got %0h exp 0", soft_reset_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL rst_ovr got %0h exp 0", overrun_o); end
    reset_i  = 1'b0;
    select_i = 1'b1;
    tick();
  endtask

  task automatic test_write();
    send(8'hC3);
    checks++; if (bus_rd_nwr_o !== 1'b0) begin errors++; $display("FAIL wr_rd_nwr got %0h exp 0", bus_rd_nwr_o); end
    checks++; if (bus_reg_num_o !== 4'h3) begin errors++; $display("FAIL wr_reg got %0h exp 3", bus_reg_num_o); end
    checks++; if (bus_cs_n_o !== 1'b1) begin errors++; $display("FAIL wr_cs_before_pay got %0h exp 1", bus_cs_n_o); end
    tick();
    send(8'h5A);
    checks++; if (bus_cs_n_o !== 1'b0) begin errors++; $display("FAIL wr_cs_c1 got %0h exp 0", bus_cs_n_o); end
    checks++; if (bus_data_o !== 8'h5A) begin errors++; $display("FAIL wr_data got %0h exp 5a", bus_data_o); end
    tick();
    checks++; if (bus_cs_n_o !== 1'b0) begin errors++; $display("FAIL wr_cs_c2 got %0h exp 0", bus_cs_n_o); end
    checks++; if (bus_rd_nwr_o !== 1'b0) begin errors++; $display("FAIL wr_rd_nwr_hold got %0h exp 0", bus_rd_nwr_o); end
    tick();
    checks++; if (bus_cs_n_o !== 1'b1) begin errors++; $display("FAIL wr_cs_c3 got %0h exp 1", bus_cs_n_o); end
    tick();
    checks++; if (bus_cs_n_o !== 1'b1) begin errors++; $display("FAIL wr_cs_c4 got %0h exp 1", bus_cs_n_o); end
    deselect();
  endtask

  task automatic test_read();
    bus_data_i = 8'hA7;
    send(8'h95);
    checks++; if (bus_cs_n_o !== 1'b0) begin errors++; $display("FAIL rd_cs_c1 got %0h exp 0", bus_cs_n_o); end
    checks++; if (bus_rd_nwr_o !== 1'b1) begin errors++; $display("FAIL rd_rd_nwr got %0h exp 1", bus_rd_nwr_o); end
    checks++; if (bus_bytesel_o !== 1'b1) begin errors++; $display("FAIL rd_bytesel got %0h exp 1", bus_bytesel_o); end
    checks++; if (bus_reg_num_o !== 4'h5) begin errors++; $display("FAIL rd_reg got %0h exp 5", bus_reg_num_o); end
    tick();
    checks++; if (bus_cs_n_o !== 1'b0) begin errors++; $display("FAIL rd_cs_c2 got %0h exp 0", bus_cs_n_o); end
    checks++; if (transmit_byte_o !== 8'hCB) begin errors++; $display("FAIL rd_tx_early got %0h exp cb", transmit_byte_o); end
    tick();
    checks++; if (bus_cs_n_o !== 1'b1) begin errors++; $display("FAIL rd_cs_c3 got %0h exp 1", bus_cs_n_o); end
    checks++; if (transmit_byte_o !== 8'hA7) begin errors++; $display("FAIL rd_tx got %0h exp a7", transmit_byte_o); end
    tick();
    checks++; if (transmit_byte_o !== 8'hA7) begin errors++; $display("FAIL rd_tx_hold got %0h exp a7", transmit_byte_o); end
    transmit_strobe_i = 1'b1;
    tick();
    transmit_strobe_i = 1'b0;
    checks++; if (transmit_byte_o !== 8'hCB) begin errors++; $display("FAIL rd_tx_clr got %0h exp cb", transmit_byte_o); end
    deselect();
    bus_data_i = 8'h3C;
    send(8'h81);
    checks++; if (bus_bytesel_o !== 1'b0) begin errors++; $display("FAIL rd2_bytesel got %0h exp 0", bus_bytesel_o); end
    tick();
    tick();
    checks++; if (transmit_byte_o !== 8'h3C) begin errors++; $display("FAIL rd2_tx got %0h exp 3c", transmit_byte_o); end
    select_i = 1'b0;
    tick();
    checks++; if (transmit_byte_o !== 8'hCB) begin errors++; $display("FAIL rd2_tx_desel got %0h exp cb", transmit_byte_o); end
    deselect();
  endtask

  task automatic test_soft_reset();
    send(8'h20);
    checks++; if (soft_reset_o !== 1'b1) begin errors++; $display("FAIL sr_pulse got %0h exp 1", soft_reset_o); end
    checks++; if (bus_cs_n_o !== 1'b1) begin errors++; $display("FAIL sr_cs_c1 got %0h exp 1", bus_cs_n_o); end
    tick();
    checks++; if (soft_reset_o !== 1'b0) begin errors++; $display("FAIL sr_end got %0h exp 0", soft_reset_o); end
    checks++; if (bus_cs_n_o !== 1'b1) begin errors++; $display("FAIL sr_cs_c2 got %0h exp 1", bus_cs_n_o); end
    deselect();
  endtask

  task automatic test_overrun();
    send(8'hC0);
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ov_init got %0h exp 0", overrun_o); end
    send(8'h77);
    checks++; if (bus_data_o !== 8'h77) begin errors++; $display("FAIL ov_data got %0h exp 77", bus_data_o); end
    send(8'h99);
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ov_set got %0h exp 1", overrun_o); end
    checks++; if (bus_data_o !== 8'h77) begin errors++; $display("FAIL ov_drop got %0h exp 77", bus_data_o); end
    checks++; if (bus_cs_n_o !== 1'b0) begin errors++; $display("FAIL ov_cs_held got %0h exp 0", bus_cs_n_o); end
    tick();
    checks++; if (bus_cs_n_o !== 1'b1) begin errors++; $display("FAIL ov_cs_end got %0h exp 1", bus_cs_n_o); end
    tick();
    checks++; if (bus_cs_n_o !== 1'b1) begin errors++; $display("FAIL ov_no_cycle got %0h exp 1", bus_cs_n_o); end
    checks++; if (overrun_o !== 1'b1) begin errors++; $display("FAIL ov_sticky got %0h exp 1", overrun_o); end
    deselect();
    send(8'h00);
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL ov_clear got %0h exp 0", overrun_o); end
    deselect();
  endtask

  task automatic test_reset_mid();
    send(8'hC3);
    send(8'h5A);
    checks++; if (bus_cs_n_o !== 1'b0) begin errors++; $display("FAIL rm_cs_active got %0h exp 0", bus_cs_n_o); end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    checks++; if (bus_cs_n_o !== 1'b1) begin errors++; $display("FAIL rm_cs got %0h exp 1", bus_cs_n_o); end
    checks++; if (bus_data_o !== 8'h00) begin errors++; $display("FAIL rm_data got %0h exp 00", bus_data_o); end
    checks++; if (bus_rd_nwr_o !== 1'b1) begin errors++; $display("FAIL rm_rd_nwr got %0h exp 1", bus_rd_nwr_o); end
    checks++; if (bus_reg_num_o !== 4'h0) begin errors++; $display("FAIL rm_reg got %0h exp 0", bus_reg_num_o); end
    bus_data_i = 8'h5E;
    send(8'h95);
    checks++; if (bus_cs_n_o !== 1'b0) begin errors++; $display("FAIL rm_cmd_cs got %0h exp 0", bus_cs_n_o); end
    tick();
    tick();
    checks++; if (transmit_byte_o !== 8'h5E) begin errors++; $display("FAIL rm_tx got %0h exp 5e", transmit_byte_o); end
    deselect();
  endtask

`ifdef SPI_BURST_EN
  task automatic test_burst();
    send(8'hC8);
    send(8'h11);
    checks++; if (bus_cs_n_o !== 1'b0) begin errors++; $display("FAIL bu_cs1 got %0h exp 0", bus_cs_n_o); end
    checks++; if (bus_bytesel_o !== 1'b0) begin errors++; $display("FAIL bu_bs1 got %0h exp 0", bus_bytesel_o); end
    checks++; if (bus_reg_num_o !== 4'h8) begin errors++; $display("FAIL bu_reg1 got %0h exp 8", bus_reg_num_o); end
    checks++; if (bus_data_o !== 8'h11) begin errors++; $display("FAIL bu_data1 got %0h exp 11", bus_data_o); end
    tick();
    tick();
    send(8'h22);
    checks++; if (bus_cs_n_o !== 1'b0) begin errors++; $display("FAIL bu_cs2 got %0h exp 0", bus_cs_n_o); end
    checks++; if (bus_bytesel_o !== 1'b1) begin errors++; $display("FAIL bu_bs2 got %0h exp 1", bus_bytesel_o); end
    checks++; if (bus_data_o !== 8'h22) begin errors++; $display("FAIL bu_data2 got %0h exp 22", bus_data_o); end
    tick();
    tick();
    send(8'h33);
    checks++; if (bus_cs_n_o !== 1'b0) begin errors++; $display("FAIL bu_cs3 got %0h exp 0", bus_cs_n_o); end
    checks++; if (bus_bytesel_o !== 1'b0) begin errors++; $display("FAIL bu_bs3 got %0h exp 0", bus_bytesel_o); end
    checks++; if (bus_data_o !== 8'h33) begin errors++; $display("FAIL bu_data3 got %0h exp 33", bus_data_o); end
    checks++; if (bus_reg_num_o !== 4'h8) begin errors++; $display("FAIL bu_reg3 got %0h exp 8", bus_reg_num_o); end
    tick();
    tick();
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL bu_ovr got %0h exp 0", overrun_o); end
    deselect();
    send(8'h95);
    checks++; if (bus_rd_nwr_o !== 1'b1) begin errors++; $display("FAIL bu_cmd_rd got %0h exp 1", bus_rd_nwr_o); end
    checks++; if (bus_reg_num_o !== 4'h5) begin errors++; $display("FAIL bu_cmd_reg got %0h exp 5", bus_reg_num_o); end
    checks++; if (bus_cs_n_o !== 1'b0) begin errors++; $display("FAIL bu_cmd_cs got %0h exp 0", bus_cs_n_o); end
    tick();
    tick();
    deselect();
  endtask
`else
  task automatic test_back_to_back();
    send(8'hC1);
    send(8'h12);
    checks++; if (bus_data_o !== 8'h12) begin errors++; $display("FAIL bb_data1 got %0h exp 12", bus_data_o); end
    tick();
    tick();
    send(8'hC2);
    checks++; if (bus_reg_num_o !== 4'h2) begin errors++; $display("FAIL bb_reg2 got %0h exp 2", bus_reg_num_o); end
    checks++; if (overrun_o !== 1'b0) begin errors++; $display("FAIL bb_ovr got %0h exp 0", overrun_o); end
    checks++; if (bus_cs_n_o !== 1'b1) begin errors++; $display("FAIL bb_cmd_nocs got %0h exp 1", bus_cs_n_o); end
    send(8'h34);
    checks++; if (bus_cs_n_o !== 1'b0) begin errors++; $display("FAIL bb_cs2 got %0h exp 0", bus_cs_n_o); end
    checks++; if (bus_data_o !== 8'h34) begin errors++; $display("FAIL bb_data2 got %0h exp 34", bus_data_o); end
    tick();
    tick();
    deselect();
  endtask
`endif

  initial begin
    reset_i           = 1'b1;
    select_i          = 1'b0;
    receive_strobe_i  = 1'b0;
    receive_byte_i    = 8'h00;
    transmit_strobe_i = 1'b0;
    bus_data_i        = 8'h00;
    test_reset();
    test_write();
    test_read();
    test_soft_reset();
    test_overrun();
`ifdef SPI_BURST_EN
    test_burst();
`else
    test_back_to_back();
`endif
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
